// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owner of the single register-file write port.
// The in-order WB stage and a multi-cycle mul/div unit compete for the port.
// Mul/div results wait in a one-entry buffer. A pending-destination scoreboard
// lets decode stall on registers still owed by mul/div. A starvation counter
// forces a one-cycle WB hold so that a full buffer is eventually drained.
module rf_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            md_issue,
  input  logic [4:0]      md_issue_rd,
  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            hazard_stall,
  output logic            wb_stall,
  output logic            rf_write_reg,
  output logic [4:0]      rf_target_reg,
  output logic [XLEN-1:0] rf_write_rd_data,
  output logic [31:0]     pending
);

  typedef enum logic [0:0] {
    NORM  = 1'b0,
    FORCE = 1'b1
  } arb_state_t;

  // The counter only has to reach STARVE_MAX-1; keep it at least one bit wide.
  localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  arb_state_t      state;
  arb_state_t      state_next;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_cnt_next;

  logic            buf_full;
  logic [4:0]      buf_rd;
  logic [XLEN-1:0] buf_data;

  logic [31:0]     pend_q;
  logic [31:0]     pend_next;

  logic            wb_grant;
  logic            buf_grant;
  logic            md_accept;

  // The buffer only accepts when it is empty, so a result can never be
  // accepted and written in the same cycle.
  assign md_ready  = !buf_full && !rst;
  assign md_accept = md_valid && md_ready;
  assign pending   = pend_q;

  // Grant selection: WB normally wins, FORCE hands the port to the buffer.
  always_comb begin
    wb_grant  = 1'b0;
    buf_grant = 1'b0;
    wb_stall  = 1'b0;
    if (!rst) begin
      if (state == FORCE) begin
        buf_grant = buf_full;
        wb_stall  = 1'b1;
      end else if (wb_valid) begin
        wb_grant = 1'b1;
      end else begin
        buf_grant = buf_full;
      end
    end
  end

  // Next-state logic: count WB wins against a full buffer, then force once.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    case (state)
      NORM: begin
        if (buf_grant) begin
          starve_cnt_next = '0;
        end else if (wb_grant && buf_full) begin
          if (starve_cnt == CNT_LAST) begin
            state_next = FORCE;
          end else begin
            starve_cnt_next = starve_cnt + 1'b1;
          end
        end
      end
      FORCE: begin
        state_next      = NORM;
        starve_cnt_next = '0;
      end
      default: begin
        state_next      = NORM;
        starve_cnt_next = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORM;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Result buffer: drained on grant, filled on accept; x0 results are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_rd   <= '0;
      buf_data <= '0;
    end else if (buf_grant) begin
      buf_full <= 1'b0;
    end else if (md_accept && (md_rd != 5'd0)) begin
      buf_full <= 1'b1;
      buf_rd   <= md_rd;
      buf_data <= md_data;
    end
  end

  // Scoreboard update: clear on buffer write, then set on issue so set wins.
  always_comb begin
    pend_next = pend_q;
    if (buf_grant) begin
      pend_next[buf_rd] = 1'b0;
    end
    if (md_issue && (md_issue_rd != 5'd0)) begin
      pend_next[md_issue_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_next;
    end
  end

  // A source is blocked if it is still owed, unless the buffer is writing it
  // right now (the register file bypasses that write to decode).
  function automatic logic src_blocked(input logic [4:0] a);
    return (a != 5'd0) && pend_q[a] && !(buf_grant && (buf_rd == a));
  endfunction

  // Decode hazard detection over both sources and the destination.
  always_comb begin
    hazard_stall = 1'b0;
    if (!rst) begin
      hazard_stall = src_blocked(dec_rs1) || src_blocked(dec_rs2) || src_blocked(dec_rd);
    end
  end

  // Write-port mux; address and data are zeroed when nobody holds the port.
  always_comb begin
    rf_write_reg     = 1'b0;
    rf_target_reg    = '0;
    rf_write_rd_data = '0;
    if (wb_grant) begin
      rf_write_reg     = (wb_rd != 5'd0);
      rf_target_reg    = wb_rd;
      rf_write_rd_data = wb_data;
    end else if (buf_grant) begin
      rf_write_reg     = (buf_rd != 5'd0);
      rf_target_reg    = buf_rd;
      rf_write_rd_data = buf_data;
    end
  end

endmodule
